// File: rtl/grid_state_ctrl.sv
// Tetris playfield owner: merges locked pieces into the grid, then collapses
// full rows bottom-up and reports how many rows each lock cleared.
//
// state | meaning
// IDLE  | waiting for a locked piece, lock_ready high
// MERGE | OR the captured cells into the grid, flag overlaps
// SCAN  | test row p for all ones, walking from the bottom row upwards
// SHIFT | drop rows 0..p-1 down by one, overwriting full row p
// DONE  | publish the per-lock count and update the running total
module grid_state_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 game_clear,
  input  logic                 lock_valid,
  output logic                 lock_ready,
  input  logic [15:0]          lock_x,
  input  logic [19:0]          lock_y,
  output logic [COLS*ROWS-1:0] grid_state,
  output logic                 busy,
  output logic                 clear_done,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          total_lines,
  output logic                 collision
);

  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     lx;
  logic [19:0]     ly;
  logic [PW-1:0]   p;
  logic [2:0]      cnt;
  logic [N-1:0]    grid, grid_merged, grid_shifted;
  logic            merge_hit, row_full;
  logic [IW-1:0]   idx;
  logic [16:0]     total_sum;
  int              xk, yk;

  // Cells are applied one at a time so a duplicate cell inside the piece
  // sees its own earlier write and counts as an overlap.
  always_comb begin
    grid_merged = grid;
    merge_hit   = 1'b0;
    idx         = '0;
    xk          = 0;
    yk          = 0;
    for (int k = 0; k < 4; k++) begin
      xk = 32'(lx[4*k +: 4]);
      yk = 32'(ly[5*k +: 5]);
      if (xk < COLS && yk < ROWS) begin
        idx = IW'(N - 1 - COLS*yk - xk);
        if (grid_merged[idx]) merge_hit = 1'b1;
        grid_merged[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    row_full     = 1'b0;
    grid_shifted = grid;
    for (int r = 0; r < ROWS; r++) begin
      if (PW'(r) == p) row_full = &grid[N-1-COLS*r -: COLS];
    end
    grid_shifted[N-1 -: COLS] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (PW'(r) <= p) grid_shifted[N-1-COLS*r -: COLS] = grid[N-1-COLS*(r-1) -: COLS];
    end
  end

  assign total_sum  = {1'b0, total_lines} + 17'(cnt);
  assign grid_state = grid;

  always_comb begin
    state_nxt  = state;
    lock_ready = 1'b0;
    busy       = 1'b1;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        lock_ready = 1'b1;
        busy       = 1'b0;
        if (lock_valid) state_nxt = MERGE;
      end
      MERGE: state_nxt = SCAN;
      SCAN: begin
        if (row_full)      state_nxt = SHIFT;
        else if (p == '0)  state_nxt = DONE;
      end
      SHIFT: state_nxt = SCAN;
      DONE: begin
        clear_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        state <= IDLE;
    else if (game_clear) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grid          <= '0;
      lx            <= '0;
      ly            <= '0;
      p             <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      collision     <= 1'b0;
    end else if (game_clear) begin
      grid          <= '0;
      lx            <= '0;
      ly            <= '0;
      p             <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      collision     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_valid) begin
            lx <= lock_x;
            ly <= lock_y;
          end
        end
        MERGE: begin
          grid <= grid_merged;
          if (merge_hit) collision <= 1'b1;
          p   <= PW'(ROWS - 1);
          cnt <= '0;
        end
        SCAN: begin
          if (!row_full && p != '0) p <= p - 1'b1;
        end
        SHIFT: begin
          grid <= grid_shifted;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          lines_cleared <= cnt;
          total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_state_ctrl.sv
// Directed bench for grid_state_ctrl: expected per-lock results are queued when
// a piece is driven and compared when the DUT pulses clear_done.
module tb_grid_state_ctrl;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          game_clear;
  logic          lock_valid;
  logic          lock_ready;
  logic [15:0]   lock_x;
  logic [19:0]   lock_y;
  logic [N-1:0]  grid_state;
  logic          busy;
  logic          clear_done;
  logic [2:0]    lines_cleared;
  logic [15:0]   total_lines;
  logic          collision;

  grid_state_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .game_clear(game_clear),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .grid_state(grid_state),
    .busy(busy), .clear_done(clear_done), .lines_cleared(lines_cleared),
    .total_lines(total_lines), .collision(collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lines;
    int          lat;
    logic [15:0] total;
  } exp_t;

  exp_t         sb[$];
  int           n_total = 0;
  int           n_bad   = 0;
  logic [15:0]  tot_m   = 16'h0;
  logic [N-1:0] snap;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [COLS-1:0] row(input int r);
    return grid_state[N-1-COLS*r -: COLS];
  endfunction

  task automatic start_lock(input logic [15:0] x, input logic [19:0] y, input int exp_lines,
                            input int exp_lat, input bit hold, input bit expect_done);
    exp_t e;
    @(negedge clk);
    check("ready_before_lock", N'(lock_ready), N'(1));
    lock_x = x;
    lock_y = y;
    lock_valid = 1'b1;
    if (expect_done) begin
      tot_m = (32'(tot_m) + exp_lines > 65535) ? 16'hFFFF : tot_m + 16'(exp_lines);
      e.lines = exp_lines;
      e.lat   = exp_lat;
      e.total = tot_m;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) lock_valid = 1'b0;
  endtask

  task automatic finish_lock();
    exp_t e;
    int   lat  = 0;
    bit   seen = 1'b0;
    e = sb.pop_front();
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (clear_done) seen = 1'b1;
    end
    lock_valid = 1'b0;
    check("clear_done_seen", N'(seen), N'(1));
    check("latency", N'(lat), N'(e.lat));
    @(negedge clk);
    check("lines_cleared", N'(lines_cleared), N'(e.lines));
    check("total_lines", N'(total_lines), N'(e.total));
  endtask

  task automatic lock(input logic [15:0] x, input logic [19:0] y, input int exp_lines, input int exp_lat);
    start_lock(x, y, exp_lines, exp_lat, 1'b0, 1'b1);
    finish_lock();
  endtask

  task automatic fill_row(input int r);
    lock(px(0, 1, 2, 3), py(r, r, r, r), 0, 22);
    lock(px(4, 5, 6, 7), py(r, r, r, r), 0, 22);
    lock(px(8, 15, 15, 15), py(r, r, r, r), 0, 22);
  endtask

  task automatic do_game_clear();
    @(negedge clk);
    game_clear = 1'b1;
    @(negedge clk);
    game_clear = 1'b0;
    tot_m = 16'h0;
  endtask

  initial begin
    reset_n    = 1'b0;
    game_clear = 1'b0;
    lock_valid = 1'b0;
    lock_x     = '0;
    lock_y     = '0;
    repeat (2) @(negedge clk);
    check("reset_grid", grid_state, '0);
    check("reset_ready", N'(lock_ready), N'(1));
    check("reset_busy", N'(busy), N'(0));
    check("reset_done", N'(clear_done), N'(0));
    check("reset_lines", N'(lines_cleared), N'(0));
    check("reset_total", N'(total_lines), N'(0));
    check("reset_collision", N'(collision), N'(0));
    reset_n = 1'b1;

    // bottom row, no clear
    lock(px(0, 1, 2, 3), py(19, 19, 19, 19), 0, 22);
    check("t1_row19", N'(row(19)), N'(10'b1111000000));

    // single clear, row 18 drops into row 19
    lock(px(4, 5, 15, 15), py(19, 19, 0, 0), 0, 22);
    fill_row(18);
    check("t2_pre_row19", N'(row(19)), N'(10'b1111110000));
    check("t2_pre_row18", N'(row(18)), N'(10'b1111111110));
    lock(px(6, 7, 8, 9), py(19, 19, 19, 19), 1, 24);
    check("t2_row19", N'(row(19)), N'(10'b1111111110));
    check("t2_row18", N'(row(18)), N'(0));
    check("t2_collision", N'(collision), N'(0));

    // four-row clear with an I-piece
    do_game_clear();
    check("gc_grid", grid_state, '0);
    check("gc_total", N'(total_lines), N'(0));
    for (int r = 16; r < 20; r++) fill_row(r);
    lock(px(9, 9, 9, 9), py(16, 17, 18, 19), 4, 30);
    check("t3_grid_empty", grid_state, '0);

    // collision is sticky until game_clear
    lock(px(0, 1, 15, 15), py(19, 19, 0, 0), 0, 22);
    check("t4_no_collision", N'(collision), N'(0));
    lock(px(1, 5, 15, 15), py(19, 19, 0, 0), 0, 22);
    check("t4_collision_set", N'(collision), N'(1));
    check("t4_cell_kept", N'(row(19)), N'(10'b1100010000));
    lock(px(7, 15, 15, 15), py(10, 0, 0, 0), 0, 22);
    check("t4_collision_sticky", N'(collision), N'(1));
    do_game_clear();
    check("t4_collision_cleared", N'(collision), N'(0));
    lock(px(3, 3, 15, 15), py(10, 10, 0, 0), 0, 22);
    check("t4_duplicate_collision", N'(collision), N'(1));
    do_game_clear();

    // lock_valid held through a sequence with changed cells: one merge only
    start_lock(px(0, 1, 2, 3), py(19, 19, 19, 18), 0, 22, 1'b1, 1'b1);
    lock_x = px(5, 6, 7, 8);
    finish_lock();
    check("t5_row19", N'(row(19)), N'(10'b1110000000));
    check("t5_row18", N'(row(18)), N'(10'b0001000000));

    // game_clear in the middle of SCAN
    start_lock(px(4, 5, 6, 7), py(0, 0, 0, 0), 0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_busy_in_scan", N'(busy), N'(1));
    game_clear = 1'b1;
    @(negedge clk);
    check("t5_abort_grid", grid_state, '0);
    check("t5_abort_ready", N'(lock_ready), N'(1));
    check("t5_abort_busy", N'(busy), N'(0));
    game_clear = 1'b0;
    tot_m = 16'h0;

    // out-of-range cells are dropped
    lock(px(0, 1, 15, 15), py(5, 5, 0, 0), 0, 22);
    snap = grid_state;
    lock(px(12, 3, 15, 9), py(5, 25, 5, 31), 0, 22);
    check("t6_grid_unchanged", grid_state, snap);
    check("t6_no_collision", N'(collision), N'(0));

    // saturating total with a two-row clear
    @(negedge clk);
    force dut.total_lines = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.total_lines;
    tot_m = 16'hFFFE;
    @(negedge clk);
    check("t6_preload", N'(total_lines), N'(16'hFFFE));
    fill_row(18);
    fill_row(19);
    lock(px(9, 9, 15, 15), py(18, 19, 0, 0), 2, 26);
    check("t6_row19", N'(row(19)), N'(0));
    check("t6_row7_dropped", N'(row(7)), N'(10'b1100000000));
    check("t6_row5_empty", N'(row(5)), N'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
